// File: rtl/k423_lsu_stage.sv
// Load/store stage: registers execute results, issues word-aligned data-memory requests, holds one completed op for write-back.
// Latency: non-mem 1, store 2, load 3 cycles (no stalls); accepts only when IDLE and the output slot is free or draining.
module k423_lsu_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_stage_vld_i,
  output logic              lsu_stage_rdy_o,
  output logic              lsu_stage_vld_o,
  input  logic              wb_stage_rdy_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_rd_vld_i,
  input  logic [4:0]        ex_rd_idx_i,
  input  logic [XLEN-1:0]   ex_rd_i,
  input  logic              ex_mem_ld_i,
  input  logic              ex_mem_st_i,
  input  logic [1:0]        ex_mem_size_i,
  input  logic              ex_mem_unsigned_i,
  input  logic [XLEN-1:0]   ex_mem_wdata_i,
  output logic              mem_data_req_vld_o,
  input  logic              mem_data_req_rdy_i,
  output logic              mem_data_req_we_o,
  output logic [ADDR_W-1:0] mem_data_req_addr_o,
  output logic [XLEN-1:0]   mem_data_req_wdata_o,
  output logic [XLEN/8-1:0] mem_data_req_wstrb_o,
  input  logic              mem_data_rsp_vld_i,
  input  logic [XLEN-1:0]   mem_data_rsp_rdata_i,
  output logic [ADDR_W-1:0] lsu_pc_o,
  output logic              lsu_rd_vld_o,
  output logic [4:0]        lsu_rd_idx_o,
  output logic [XLEN-1:0]   lsu_rd_o,
  output logic              lsu_rd_load_o,
  output logic [1:0]        lsu_rd_load_size_o,
  output logic              lsu_rd_load_unsigned_o,
  output logic [ADDR_W-1:0] lsu_rd_load_addr_o,
  output logic [XLEN-1:0]   lsu_load_rdata_o,
  output logic              lsu_misalign_o
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q;
  logic              stage_vld_q;
  logic [ADDR_W-1:0] pc_q;
  logic              rd_vld_q;
  logic [4:0]        rd_idx_q;
  logic [XLEN-1:0]   rd_q;
  logic              ld_q;
  logic [1:0]        ld_size_q;
  logic              ld_unsigned_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [XLEN-1:0]   ld_rdata_q;
  logic              misalign_q;
  logic              req_vld_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [NB-1:0]     req_wstrb_q;

  logic              accept;
  logic              drain;
  logic              is_mem;
  logic              misalign;
  logic              aligned_mem;
  logic [1:0]        byte_off;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] req_addr_d;
  logic [XLEN-1:0]   req_wdata_d;
  logic [NB-1:0]     req_wstrb_d;

  assign lsu_stage_rdy_o = (state_q == IDLE) & (~stage_vld_q | wb_stage_rdy_i);
  assign accept          = ex_stage_vld_i & lsu_stage_rdy_o;
  assign drain           = stage_vld_q & wb_stage_rdy_i;

  assign eff_addr    = ADDR_W'(ex_rd_i);
  assign byte_off    = ex_rd_i[1:0];
  assign is_mem      = ex_mem_ld_i | ex_mem_st_i;
  assign aligned_mem = is_mem & ~misalign;
  assign req_addr_d  = {eff_addr[ADDR_W-1:2], 2'b00};

  // Size encoding 11 is treated like a word for alignment purposes.
  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      case (ex_mem_size_i)
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = byte_off[0];
        default: misalign = (byte_off != 2'b00);
      endcase
    end
  end

  // Stores replicate the datum across all lanes; strobes select the addressed bytes.
  always_comb begin
    req_wstrb_d = '0;
    req_wdata_d = '0;
    if (ex_mem_st_i) begin
      case (ex_mem_size_i)
        2'b00: begin
          req_wstrb_d = NB'(1) << byte_off;
          req_wdata_d = {NB{ex_mem_wdata_i[7:0]}};
        end
        2'b01: begin
          req_wstrb_d = NB'(3) << byte_off;
          req_wdata_d = {(NB/2){ex_mem_wdata_i[15:0]}};
        end
        default: begin
          req_wstrb_d = '1;
          req_wdata_d = ex_mem_wdata_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      stage_vld_q   <= 1'b0;
      pc_q          <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      rd_q          <= '0;
      ld_q          <= 1'b0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      ld_addr_q     <= '0;
      ld_rdata_q    <= '0;
      misalign_q    <= 1'b0;
      req_vld_q     <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pc_q          <= ex_pc_i;
            rd_vld_q      <= ex_rd_vld_i & ~misalign;
            rd_idx_q      <= ex_rd_idx_i;
            rd_q          <= ex_rd_i;
            ld_q          <= ex_mem_ld_i & ~misalign;
            ld_size_q     <= ex_mem_size_i;
            ld_unsigned_q <= ex_mem_unsigned_i;
            ld_addr_q     <= eff_addr;
            ld_rdata_q    <= '0;
            misalign_q    <= misalign;
            if (aligned_mem) begin
              state_q     <= REQ;
              stage_vld_q <= 1'b0;
              req_vld_q   <= 1'b1;
              req_we_q    <= ex_mem_st_i;
              req_addr_q  <= req_addr_d;
              req_wdata_q <= req_wdata_d;
              req_wstrb_q <= req_wstrb_d;
            end else begin
              stage_vld_q <= 1'b1;
            end
          end else if (drain) begin
            stage_vld_q <= 1'b0;
          end
        end
        REQ: begin
          if (mem_data_req_rdy_i) begin
            req_vld_q <= 1'b0;
            if (req_we_q) begin
              state_q     <= IDLE;
              stage_vld_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_data_rsp_vld_i) begin
            ld_rdata_q  <= mem_data_rsp_rdata_i;
            stage_vld_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_stage_vld_o        = stage_vld_q;
  assign lsu_pc_o               = pc_q;
  assign lsu_rd_vld_o           = rd_vld_q;
  assign lsu_rd_idx_o           = rd_idx_q;
  assign lsu_rd_o               = rd_q;
  assign lsu_rd_load_o          = ld_q;
  assign lsu_rd_load_size_o     = ld_size_q;
  assign lsu_rd_load_unsigned_o = ld_unsigned_q;
  assign lsu_rd_load_addr_o     = ld_addr_q;
  assign lsu_load_rdata_o       = ld_rdata_q;
  assign lsu_misalign_o         = misalign_q;

  assign mem_data_req_vld_o   = req_vld_q;
  assign mem_data_req_we_o    = req_we_q;
  assign mem_data_req_addr_o  = req_addr_q;
  assign mem_data_req_wdata_o = req_wdata_q;
  assign mem_data_req_wstrb_o = req_wstrb_q;

endmodule

// File: tb/tb_k423_lsu_stage.sv
// Bench for k423_lsu_stage: directed ops, a queue-based reference model, a scripted memory responder
// and one per-cycle compare process.
`timescale 1ns/1ps
module tb_k423_lsu_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_stage_vld_i;
  logic        lsu_stage_rdy_o;
  logic        lsu_stage_vld_o;
  logic        wb_stage_rdy_i;
  logic [31:0] ex_pc_i;
  logic        ex_rd_vld_i;
  logic [4:0]  ex_rd_idx_i;
  logic [31:0] ex_rd_i;
  logic        ex_mem_ld_i;
  logic        ex_mem_st_i;
  logic [1:0]  ex_mem_size_i;
  logic        ex_mem_unsigned_i;
  logic [31:0] ex_mem_wdata_i;
  logic        mem_data_req_vld_o;
  logic        mem_data_req_rdy_i;
  logic        mem_data_req_we_o;
  logic [31:0] mem_data_req_addr_o;
  logic [31:0] mem_data_req_wdata_o;
  logic [3:0]  mem_data_req_wstrb_o;
  logic        mem_data_rsp_vld_i;
  logic [31:0] mem_data_rsp_rdata_i;
  logic [31:0] lsu_pc_o;
  logic        lsu_rd_vld_o;
  logic [4:0]  lsu_rd_idx_o;
  logic [31:0] lsu_rd_o;
  logic        lsu_rd_load_o;
  logic [1:0]  lsu_rd_load_size_o;
  logic        lsu_rd_load_unsigned_o;
  logic [31:0] lsu_rd_load_addr_o;
  logic [31:0] lsu_load_rdata_o;
  logic        lsu_misalign_o;

  always #5 clk_i = ~clk_i;

  k423_lsu_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_stage_vld_i(ex_stage_vld_i), .lsu_stage_rdy_o(lsu_stage_rdy_o),
    .lsu_stage_vld_o(lsu_stage_vld_o), .wb_stage_rdy_i(wb_stage_rdy_i),
    .ex_pc_i(ex_pc_i), .ex_rd_vld_i(ex_rd_vld_i), .ex_rd_idx_i(ex_rd_idx_i), .ex_rd_i(ex_rd_i),
    .ex_mem_ld_i(ex_mem_ld_i), .ex_mem_st_i(ex_mem_st_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_mem_unsigned_i(ex_mem_unsigned_i), .ex_mem_wdata_i(ex_mem_wdata_i),
    .mem_data_req_vld_o(mem_data_req_vld_o), .mem_data_req_rdy_i(mem_data_req_rdy_i),
    .mem_data_req_we_o(mem_data_req_we_o), .mem_data_req_addr_o(mem_data_req_addr_o),
    .mem_data_req_wdata_o(mem_data_req_wdata_o), .mem_data_req_wstrb_o(mem_data_req_wstrb_o),
    .mem_data_rsp_vld_i(mem_data_rsp_vld_i), .mem_data_rsp_rdata_i(mem_data_rsp_rdata_i),
    .lsu_pc_o(lsu_pc_o), .lsu_rd_vld_o(lsu_rd_vld_o), .lsu_rd_idx_o(lsu_rd_idx_o), .lsu_rd_o(lsu_rd_o),
    .lsu_rd_load_o(lsu_rd_load_o), .lsu_rd_load_size_o(lsu_rd_load_size_o),
    .lsu_rd_load_unsigned_o(lsu_rd_load_unsigned_o), .lsu_rd_load_addr_o(lsu_rd_load_addr_o),
    .lsu_load_rdata_o(lsu_load_rdata_o), .lsu_misalign_o(lsu_misalign_o)
  );

  typedef struct {
    logic [31:0] pc; logic rd_vld; logic [4:0] idx; logic [31:0] rd;
    logic ld; logic st; logic [1:0] size; logic uns; logic [31:0] wdata; logic [31:0] rdata;
    int stall; int rsp_extra; bit chk_lat;
  } op_t;
  typedef logic [138:0] outv_t;
  typedef struct { outv_t v; int acc; int lat; } exp_t;
  typedef struct { logic [68:0] v; bit chk_wdata; } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_left = 0;
  int   rsp_extra_g = 0;
  logic [31:0] next_rdata = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [31:0] pc, input logic rd_vld, input logic [4:0] idx,
                             input logic [31:0] rd, input logic ld, input logic st, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                             input int stall, input int extra, input bit chk_lat);
    op_t o;
    o.pc = pc; o.rd_vld = rd_vld; o.idx = idx; o.rd = rd; o.ld = ld; o.st = st; o.size = size;
    o.uns = uns; o.wdata = wdata; o.rdata = rdata; o.stall = stall; o.rsp_extra = extra; o.chk_lat = chk_lat;
    return o;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input op_t o);
    return (o.ld || o.st) && ((o.rd % nbytes(o.size)) != 0);
  endfunction

  // Reference: what write-back must see and what memory must be asked for.
  task automatic model_push(input op_t o, input int acc);
    exp_t e;
    req_t r;
    bit   mis = is_mis(o);
    bit   mem = (o.ld || o.st) && !mis;
    int   n = nbytes(o.size);
    int   off = o.rd % 4;
    logic [3:0]  strb = '0;
    logic [31:0] wd = '0;
    e.v = {o.pc, o.rd_vld & ~mis, o.idx, o.rd, o.ld & ~mis, o.size, o.uns, o.rd,
           (o.ld && mem) ? o.rdata : 32'h0, mis};
    e.acc = acc;
    e.lat = !o.chk_lat ? -1 : !mem ? 1 : o.st ? 2 + o.stall : 3 + o.stall + o.rsp_extra;
    exp_q.push_back(e);
    if (mem) begin
      for (int i = 0; i < 4; i++) begin
        if (o.st && i >= off && i < off + n) strb[i] = 1'b1;
        wd[i*8 +: 8] = o.wdata[(i % n)*8 +: 8];
      end
      r.v = {o.rd - 32'(off), o.st, strb, o.st ? wd : 32'h0};
      r.chk_wdata = o.st;
      req_q.push_back(r);
    end
  endtask

  task automatic drive_op(input op_t o);
    ex_stage_vld_i = 1'b1; ex_pc_i = o.pc; ex_rd_vld_i = o.rd_vld; ex_rd_idx_i = o.idx; ex_rd_i = o.rd;
    ex_mem_ld_i = o.ld; ex_mem_st_i = o.st; ex_mem_size_i = o.size; ex_mem_unsigned_i = o.uns;
    ex_mem_wdata_i = o.wdata;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_op(input op_t o);
    bit ok = 0;
    drive_op(o);
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk_i);
      if (lsu_stage_rdy_o && !rst_i) begin
        ok = 1;
        model_push(o, cyc);
        stall_left = o.stall; rsp_extra_g = o.rsp_extra; next_rdata = o.rdata;
      end
      @(posedge clk_i); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout pc=%0h never accepted", o.pc);
    end
    ex_stage_vld_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk_i);
      done = (exp_q.size() == 0) && (req_q.size() == 0);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending_out=%0d pending_req=%0d", exp_q.size(), req_q.size());
      exp_q.delete(); req_q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  // Memory responder: holds rdy low for stall_left cycles, answers loads after rsp_extra cycles.
  initial begin
    bit hs, hs_we, pend;
    int wait_n;
    logic [31:0] word;
    pend = 0; wait_n = 0; word = '0;
    mem_data_req_rdy_i = 1'b0; mem_data_rsp_vld_i = 1'b0; mem_data_rsp_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      hs = mem_data_req_vld_o && mem_data_req_rdy_i && !rst_i;
      hs_we = mem_data_req_we_o;
      @(posedge clk_i); #1;
      mem_data_rsp_vld_i = 1'b0;
      if (hs && !hs_we) begin pend = 1; wait_n = rsp_extra_g; word = next_rdata; end
      if (pend) begin
        if (wait_n > 0) wait_n--;
        else begin mem_data_rsp_vld_i = 1'b1; mem_data_rsp_rdata_i = word; pend = 0; end
      end
      if (mem_data_req_vld_o && !rst_i) begin
        if (stall_left > 0) begin mem_data_req_rdy_i = 1'b0; stall_left--; end
        else mem_data_req_rdy_i = 1'b1;
      end else mem_data_req_rdy_i = 1'b0;
    end
  end

  // Single compare process against the model, every cycle outputs are meaningful.
  always @(negedge clk_i) begin
    if (rst_i !== 1'b1 && cyc > 0) begin
      if (lsu_stage_vld_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_vld pc=%0h", lsu_pc_o);
        end else begin
          chk("out_fields", {lsu_pc_o, lsu_rd_vld_o, lsu_rd_idx_o, lsu_rd_o, lsu_rd_load_o,
              lsu_rd_load_size_o, lsu_rd_load_unsigned_o, lsu_rd_load_addr_o, lsu_load_rdata_o,
              lsu_misalign_o}, exp_q[0].v);
          if (wb_stage_rdy_i) begin
            if (exp_q[0].lat >= 0) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            void'(exp_q.pop_front());
          end
        end
      end
      if (mem_data_req_vld_o) begin
        if (req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req addr=%0h", mem_data_req_addr_o);
        end else begin
          chk("req_fields", {mem_data_req_addr_o, mem_data_req_we_o, mem_data_req_wstrb_o,
              req_q[0].chk_wdata ? mem_data_req_wdata_o : 32'h0}, req_q[0].v);
          if (mem_data_req_rdy_i) void'(req_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_i = 1'b1; wb_stage_rdy_i = 1'b1; ex_stage_vld_i = 1'b0;
    ex_pc_i = '0; ex_rd_vld_i = 1'b0; ex_rd_idx_i = '0; ex_rd_i = '0; ex_mem_ld_i = 1'b0;
    ex_mem_st_i = 1'b0; ex_mem_size_i = '0; ex_mem_unsigned_i = 1'b0; ex_mem_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("reset_vld", lsu_stage_vld_o, 0);
    chk("reset_req_vld", mem_data_req_vld_o, 0);
    chk("reset_rdy", lsu_stage_rdy_o, 1);
    chk("reset_rd", lsu_rd_o, 0);
    @(posedge clk_i); #1;

    // Back-to-back ALU ops.
    send_op(mk(32'h0, 1, 5'd1, 32'h11, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    send_op(mk(32'h4, 1, 5'd2, 32'h22, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    send_op(mk(32'h8, 1, 5'd3, 32'h33, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    chk("alu_last_pc", lsu_pc_o, 32'h8);
    chk("alu_last_rd", lsu_rd_o, 32'h33);
    chk("alu_no_req", mem_data_req_vld_o, 0);
    wait_idle();

    // Byte store at 0x1003.
    send_op(mk(32'h10, 0, 5'd0, 32'h1003, 0, 1, 2'd0, 0, 32'h123456A5, 0, 0, 0, 1));
    @(negedge clk_i);
    chk("st_b_req_vld", mem_data_req_vld_o, 1);
    chk("st_b_addr", mem_data_req_addr_o, 32'h1000);
    chk("st_b_wstrb", mem_data_req_wstrb_o, 4'b1000);
    chk("st_b_wdata", mem_data_req_wdata_o, 32'hA5A5A5A5);
    chk("st_b_we", mem_data_req_we_o, 1);
    @(negedge clk_i);
    chk("st_b_vld_n2", lsu_stage_vld_o, 1);
    wait_idle();

    // Signed half load at 0x2002 with request stalled 3 cycles.
    send_op(mk(32'h14, 1, 5'd7, 32'h2002, 1, 0, 2'd1, 0, 0, 32'h80011234, 3, 0, 1));
    k = 0;
    while (!lsu_stage_vld_o && k < 50) begin
      @(negedge clk_i);
      k++;
      if (k == 1) chk("ld_h_req_addr", {mem_data_req_vld_o, mem_data_req_addr_o, mem_data_req_we_o,
                                        mem_data_req_wstrb_o}, {1'b1, 32'h2000, 1'b0, 4'b0000});
    end
    chk("ld_h_cycles", k, 6);
    chk("ld_h_rdata", lsu_load_rdata_o, 32'h80011234);
    chk("ld_h_attrs", {lsu_rd_load_o, lsu_rd_load_size_o, lsu_rd_load_unsigned_o, lsu_rd_load_addr_o},
        {1'b1, 2'b01, 1'b0, 32'h2002});
    @(posedge clk_i); #1;
    wait_idle();

    // Write-back stalls 4 cycles; the next op must wait.
    wb_stage_rdy_i = 1'b0;
    send_op(mk(32'h100, 1, 5'd9, 32'hAAAA, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    drive_op(mk(32'h104, 1, 5'd10, 32'hBBBB, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    repeat (4) begin
      @(negedge clk_i);
      chk("hold_rdy", lsu_stage_rdy_o, 0);
      chk("hold_pc", {lsu_stage_vld_o, lsu_pc_o}, {1'b1, 32'h100});
      @(posedge clk_i); #1;
    end
    wb_stage_rdy_i = 1'b1;
    send_op(mk(32'h104, 1, 5'd10, 32'hBBBB, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    wait_idle();

    // Misaligned word load.
    send_op(mk(32'h20, 1, 5'd4, 32'h3001, 1, 0, 2'd2, 0, 0, 32'hFFFFFFFF, 0, 0, 1));
    @(negedge clk_i);
    chk("mis_flags", {lsu_stage_vld_o, lsu_misalign_o, lsu_rd_vld_o, mem_data_req_vld_o}, 4'b1100);
    wait_idle();

    // Further lane/size patterns.
    send_op(mk(32'h24, 0, 5'd0, 32'h1002, 0, 1, 2'd1, 0, 32'h1234BEEF, 0, 0, 0, 1));
    send_op(mk(32'h28, 0, 5'd0, 32'h1010, 0, 1, 2'd2, 0, 32'hCAFEF00D, 0, 1, 0, 1));
    send_op(mk(32'h2C, 1, 5'd5, 32'h2007, 1, 0, 2'd0, 1, 0, 32'h11223344, 0, 2, 1));
    send_op(mk(32'h30, 0, 5'd0, 32'h2001, 0, 1, 2'd1, 0, 32'h5555, 0, 0, 0, 1));
    send_op(mk(32'h34, 1, 5'd6, 32'h2003, 1, 0, 2'd1, 1, 0, 0, 0, 0, 1));
    wait_idle();

    // Reset while waiting for a load response; the late response must be ignored.
    send_op(mk(32'h40, 1, 5'd8, 32'h4000, 1, 0, 2'd2, 0, 0, 32'hDEADBEEF, 0, 3, 1));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_q.delete(); req_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      chk("post_rst_idle", {lsu_stage_vld_o, mem_data_req_vld_o, lsu_load_rdata_o}, 34'h0);
      @(posedge clk_i); #1;
    end
    send_op(mk(32'h44, 1, 5'd11, 32'h7777, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    chk("post_rst_accept", {lsu_stage_vld_o, lsu_pc_o}, {1'b1, 32'h44});
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
